// File: rtl/loop_sched_pkg.sv
// Shared types and default constants for the two-requester loop scheduler.
// Pure declarations; no timing or flow-control behaviour of its own.
package loop_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int W_DEF       = 23;
    localparam int I_INIT_DEF  = 1;
    localparam int J_INIT_DEF  = 1000;
    localparam int J_FLOOR_DEF = 666;
    localparam int A_DI_DEF    = 2;
    localparam int A_DJ_DEF    = 1;
    localparam int B_DI_DEF    = 1;
    localparam int B_DJ_DEF    = 2;
    localparam int STEP_W      = 16;

endpackage

// File: rtl/loop_rr_pick.sv
// Two-way round-robin picker; ptr_i names the requester favoured on a tie.
// Purely combinational; ptr_o moves away from the winner only when something is granted.
module loop_rr_pick (
    input  logic [1:0] cand_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o,
    output logic       ptr_o
);

    always_comb begin
        gnt_o = 2'b00;
        ptr_o = ptr_i;
        case (cand_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
        if (gnt_o[0]) begin
            ptr_o = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_o = 1'b0;
        end
    end

endmodule

// File: rtl/loop_pair_scheduler.sv
// Round-robin scheduler of two step requesters onto one shared i/j loop; LOOP_SCHED_ASSERT_EN adds assertions.
// Grant is combinational and counters update on the grant edge; no backpressure, ungranted requests simply wait.
module loop_pair_scheduler
    import loop_sched_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int I_INIT  = I_INIT_DEF,
    parameter int J_INIT  = J_INIT_DEF,
    parameter int J_FLOOR = J_FLOOR_DEF,
    parameter int A_DI    = A_DI_DEF,
    parameter int A_DJ    = A_DJ_DEF,
    parameter int B_DI    = B_DI_DEF,
    parameter int B_DJ    = B_DJ_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        req,
    output logic [1:0]        gnt,
    output logic [W-1:0]      i,
    output logic [W-1:0]      j,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] steps
);

    state_e            state_q, state_d;
    logic [W-1:0]      i_q, i_d, j_q, j_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic              ptr_q, ptr_d;
    logic              elig_a, elig_b;
    logic [1:0]        pick_gnt;
    logic              pick_ptr;

    // One extra bit keeps the floor+step sums from wrapping at narrow W.
    assign elig_a = ({1'b0, j_q} >= {1'b0, i_q}) && ({1'b0, j_q} >= (W+1)'(J_FLOOR + A_DJ));
    assign elig_b = ({1'b0, j_q} >= {1'b0, i_q}) && ({1'b0, j_q} >= (W+1)'(J_FLOOR + B_DJ));

    loop_rr_pick u_pick (
        .cand_i (req & {elig_b, elig_a}),
        .ptr_i  (ptr_q),
        .gnt_o  (pick_gnt),
        .ptr_o  (pick_ptr)
    );

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        steps_d = steps_q;
        ptr_d   = ptr_q;
        gnt     = 2'b00;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    i_d     = W'(I_INIT);
                    j_d     = W'(J_INIT);
                    steps_d = '0;
                end
            end
            RUN: begin
                gnt = pick_gnt;
                if (gnt[0]) begin
                    i_d = i_q + W'(A_DI);
                    j_d = j_q - W'(A_DJ);
                end else if (gnt[1]) begin
                    i_d = i_q + W'(B_DI);
                    j_d = j_q - W'(B_DJ);
                end
                if (gnt != 2'b00) begin
                    ptr_d = pick_ptr;
                    if (steps_q != '1) begin
                        steps_d = steps_q + STEP_W'(1);
                    end
                end
                if (!elig_a && !elig_b) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= W'(I_INIT);
            j_q     <= W'(J_INIT);
            steps_q <= '0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            steps_q <= steps_d;
            ptr_q   <= ptr_d;
        end
    end

    assign i     = i_q;
    assign j     = j_q;
    assign steps = steps_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);

`ifdef LOOP_SCHED_ASSERT_EN
    logic reload;
    assign reload = (state_q != RUN) && start;

    a_j_range: assert property (@(posedge clk) disable iff (rst)
        (j_q <= W'(J_INIT)) && (j_q >= W'(J_FLOOR)));
    a_gnt_onehot: assert property (@(posedge clk) $onehot0(gnt));
    a_gnt_run: assert property (@(posedge clk) (gnt != 2'b00) |-> (state_q == RUN));
    a_hold: assert property (@(posedge clk) disable iff (rst)
        ((gnt == 2'b00) && !reload) |=> ($stable(i_q) && $stable(j_q)));
`else
`endif

endmodule

// File: tb/tb_loop_pair_scheduler.sv
// Scoreboard bench for loop_pair_scheduler: stimulus queues expected grants and terminations, a monitor checks them.
module tb_loop_pair_scheduler;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [22:0] i;
    logic [22:0] j;
    logic        busy;
    logic        done;
    logic [15:0] steps;

    typedef struct {
        logic [1:0] g;
        int         i;
        int         j;
        int         s;
    } grant_t;

    typedef struct {
        int i;
        int j;
        int s;
    } term_t;

    grant_t gq[$];
    term_t  tq[$];

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int exp_steps  = 0;
    int last_gnt_cyc = 0;
    logic done_prev = 1'b0;

    loop_pair_scheduler dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .req   (req),
        .gnt   (gnt),
        .i     (i),
        .j     (j),
        .busy  (busy),
        .done  (done),
        .steps (steps)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_grant(input logic [1:0] g, input int ei, input int ej);
        grant_t e;
        e.g = g;
        e.i = ei;
        e.j = ej;
        e.s = exp_steps;
        gq.push_back(e);
        exp_steps++;
    endtask

    task automatic push_term(input int ei, input int ej, input int es);
        term_t t;
        t.i = ei;
        t.j = ej;
        t.s = es;
        tq.push_back(t);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        req   = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        exp_steps = 0;
    endtask

    task automatic wait_done(input string name);
        for (int n = 0; n < 1000 && !done; n++) tick();
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got done=0 expected done=1 within 1000 cycles", name);
        end
        tick();
    endtask

    // Monitor: every visible grant and every rise of done must match the next queued expectation.
    initial begin
        grant_t e;
        term_t  t;
        forever begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                if (gq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_grant: got gnt=%0d expected no grant", gnt);
                end else begin
                    e = gq.pop_front();
                    chk("grant_gnt", 32'(gnt), 32'(e.g));
                    chk("grant_i", 32'(i), 32'(e.i));
                    chk("grant_j", 32'(j), 32'(e.j));
                    chk("grant_steps", 32'(steps), 32'(e.s));
                end
                last_gnt_cyc = cyc;
            end
            if (done && !done_prev) begin
                if (tq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done=1 expected done=0");
                end else begin
                    t = tq.pop_front();
                    chk("term_i", 32'(i), 32'(t.i));
                    chk("term_j", 32'(j), 32'(t.j));
                    chk("term_steps", 32'(steps), 32'(t.s));
                    chk("term_busy", 32'(busy), 32'd0);
                    chk("term_done_gap", 32'(cyc - last_gnt_cyc), 32'd2);
                end
            end
            done_prev = done;
        end
    end

    initial begin
        int ei;
        int ej;

        rst   = 1'b1;
        start = 1'b0;
        req   = 2'b00;
        do_reset();

        // Reset state, with req active to show it is ignored in IDLE.
        req = 2'b11;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_i", 32'(i), 32'd1);
        chk("rst_j", 32'(j), 32'd1000);
        chk("rst_steps", 32'(steps), 32'd0);

        // A-only: i = 1+2k, j = 1000-k for k = 0..333.
        do_reset();
        for (int k = 0; k < 334; k++) push_grant(2'b01, 1 + 2 * k, 1000 - k);
        push_term(669, 666, 334);
        req   = 2'b01;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("a_only");
        req = 2'b00;

        // B-only: i = 1+k, j = 1000-2k for k = 0..166.
        do_reset();
        for (int k = 0; k < 167; k++) push_grant(2'b10, 1 + k, 1000 - 2 * k);
        push_term(168, 666, 167);
        req   = 2'b10;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("b_only");
        req = 2'b00;

        // Both requesting: alternate A,B from A; 223 grants, last one A.
        do_reset();
        ei = 1;
        ej = 1000;
        for (int k = 0; k < 223; k++) begin
            if (k % 2 == 0) begin
                push_grant(2'b01, ei, ej);
                ei += 2;
                ej -= 1;
            end else begin
                push_grant(2'b10, ei, ej);
                ei += 1;
                ej -= 2;
            end
        end
        push_term(336, 666, 223);
        req   = 2'b11;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("both");
        req = 2'b00;

        // 111 B then 111 A reaches i=334, j=667 with B favoured; B is ineligible so A wins.
        do_reset();
        for (int k = 0; k < 111; k++) push_grant(2'b10, 1 + k, 1000 - 2 * k);
        for (int k = 0; k < 111; k++) push_grant(2'b01, 112 + 2 * k, 778 - k);
        push_grant(2'b01, 334, 667);
        push_term(336, 666, 223);
        req   = 2'b10;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 111; k++) tick();
        req = 2'b01;
        for (int k = 0; k < 111; k++) tick();
        req = 2'b11;
        wait_done("inelig_pref");
        req = 2'b00;

        // DONE holds without start, then start reloads and req=0 holds counters.
        tick();
        tick();
        chk("done_hold", 32'(done), 32'd1);
        chk("done_hold_i", 32'(i), 32'd336);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_i", 32'(i), 32'd1);
        chk("restart_j", 32'(j), 32'd1000);
        chk("restart_steps", 32'(steps), 32'd0);
        tick();
        tick();
        chk("idle_req_gnt", 32'(gnt), 32'd0);
        chk("idle_req_i", 32'(i), 32'd1);
        chk("idle_req_j", 32'(j), 32'd1000);
        chk("idle_req_busy", 32'(busy), 32'd1);

        // Mid-run reset after 50 A grants; a start pulse in RUN must not reload.
        do_reset();
        exp_steps = 0;
        for (int k = 0; k < 50; k++) push_grant(2'b01, 1 + 2 * k, 1000 - k);
        req   = 2'b01;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            start = (k >= 20 && k < 23);
            tick();
        end
        start = 1'b0;
        rst   = 1'b1;
        req   = 2'b00;
        tick();
        rst = 1'b0;
        req = 2'b01;
        #1;
        chk("midrst_i", 32'(i), 32'd1);
        chk("midrst_j", 32'(j), 32'd1000);
        chk("midrst_steps", 32'(steps), 32'd0);
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        req = 2'b00;
        tick();
        tick();

        chk("grant_queue_left", 32'(gq.size()), 32'd0);
        chk("term_queue_left", 32'(tq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
